cpu_register: RTL and testbench

- Single WIDTH-bit storage register with write enable, per-byte write mask and synchronous clear.
- Basic storage cell of the CPU register file; 32 instances form the 32-entry file.
- Entry 0 is hardwired to write constant zero.
- Output is always the stored value; there is no read port logic.

---
 rtl/cpu_register.sv | 103 ++++++++++
 tb/tb_cpu_register.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpu_register.sv
// -----------------------------------------------------------------------------
// cpu_register
//
// Single WIDTH-bit storage register used as one entry of the CPU register
// file. It supports a write enable, a per-byte write mask and a synchronous
// clear. The stored value is driven straight from flops.
//
// Optional feature macro: REGISTER_PARITY_EN
//   When defined, adds a Parity output backed by a flop. The flop holds the
//   XOR reduction of the value that Dout will show.
//
// Parameters:
//   WIDTH        data width in bits (multiple of 8, >= 8)
//   RESET_VALUE  value loaded into the register while Rst_n is low
//   NBYTES       derived byte-lane count (WIDTH/8), not overridable
//
// Ports:
//   Clk       in   rising-edge clock
//   Rst_n     in   asynchronous active-low reset
//   WE        in   write enable
//   Clr       in   synchronous clear to zero (wins over WE)
//   ByteEn    in   per-byte write mask, bit k gates Data[8k+7:8k]
//   Data      in   write data
//   Dout      out  stored value
//   Wr_Pulse  out  high for one cycle after a write or clear updated the value
//   Parity    out  XOR reduction of the stored value (REGISTER_PARITY_EN only)
// -----------------------------------------------------------------------------
module cpu_register #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
    localparam int unsigned          NBYTES      = WIDTH / 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WE,
    input  logic              Clr,
    input  logic [NBYTES-1:0] ByteEn,
    input  logic [WIDTH-1:0]  Data,
    output logic [WIDTH-1:0]  Dout,
`ifdef REGISTER_PARITY_EN
    output logic              Wr_Pulse,
    output logic              Parity
`else
    output logic              Wr_Pulse
`endif
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             pulse_q;
    logic             pulse_d;

    // Next-state: Clr beats WE, WE beats hold. A write with an empty byte
    // mask leaves the value untouched and does not raise the pulse.
    always_comb begin
        dout_d  = dout_q;
        pulse_d = 1'b0;
        if (Clr) begin
            dout_d  = '0;
            pulse_d = 1'b1;
        end else if (WE) begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (ByteEn[k]) begin
                    dout_d[8*k +: 8] = Data[8*k +: 8];
                end
            end
            pulse_d = |ByteEn;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            dout_q  <= RESET_VALUE;
            pulse_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            pulse_q <= pulse_d;
        end
    end

    assign Dout     = dout_q;
    assign Wr_Pulse = pulse_q;

`ifdef REGISTER_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Parity is taken over the merged next value so that byte-masked writes
    // account for the lanes that were kept.
    assign parity_d = ^dout_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            parity_q <= ^RESET_VALUE;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign Parity = parity_q;
`endif

endmodule

// File: tb/tb_cpu_register.sv
module tb_cpu_register;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NBYTES = WIDTH / 8;

    logic              Clk;
    logic              Rst_n;
    logic              WE;
    logic              Clr;
    logic [NBYTES-1:0] ByteEn;
    logic [WIDTH-1:0]  Data;
    logic [WIDTH-1:0]  Dout;
    logic              Wr_Pulse;
`ifdef REGISTER_PARITY_EN
    logic              Parity;
`endif

    int checks   = 0;
    int failures = 0;

    cpu_register #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .WE       (WE),
        .Clr      (Clr),
        .ByteEn   (ByteEn),
        .Data     (Data),
        .Dout     (Dout),
`ifdef REGISTER_PARITY_EN
        .Wr_Pulse (Wr_Pulse),
        .Parity   (Parity)
`else
        .Wr_Pulse (Wr_Pulse)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic              clr;
        logic              we;
        logic [NBYTES-1:0] be;
        logic [WIDTH-1:0]  data;
        logic [WIDTH-1:0]  exp_dout;
        logic              exp_pulse;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [WIDTH-1:0] exp_dout,
                             input logic exp_pulse);
        check({name, ".dout"}, Dout, exp_dout);
        check({name, ".pulse"}, {31'd0, Wr_Pulse}, {31'd0, exp_pulse});
`ifdef REGISTER_PARITY_EN
        check({name, ".parity"}, {31'd0, Parity}, {31'd0, ^exp_dout});
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, settle just after it.
    task automatic apply(input logic clr, input logic we,
                         input logic [NBYTES-1:0] be, input logic [WIDTH-1:0] data);
        Clr    = clr;
        WE     = we;
        ByteEn = be;
        Data   = data;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] byte_mask(input logic [NBYTES-1:0] be);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < int'(NBYTES); k++)
            if (be[k]) m[8*k +: 8] = 8'hFF;
        return m;
    endfunction

    logic [WIDTH-1:0] model_q;
    logic             model_pulse;
    logic [WIDTH-1:0] m;
    logic             rclr, rwe;
    logic [NBYTES-1:0] rbe;
    logic [WIDTH-1:0] rdata;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'hF, 32'h12345678, 32'h12345678, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 4'hF, 32'hFFFFFFFF, 32'h12345678, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'h5, 32'hAABBCCDD, 32'h12BB56DD, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 4'h0, 32'h00000005, 32'h12BB56DD, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 4'h0, 32'h00000000, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4'h8, 32'hA5FFFFFF, 32'hA5000000, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'h2, 32'h11223C44, 32'hA5003C00, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 4'hF, 32'h00000007, 32'h00000007, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 4'hF, 32'h00000003, 32'h00000003, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 4'hF, 32'h00000003, 32'h00000000, 1'b1};

        Rst_n  = 1'b0;
        WE     = 1'b0;
        Clr    = 1'b0;
        ByteEn = '0;
        Data   = '0;
        #12;
        check_all("reset", 32'h0, 1'b0);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Table vectors, applied back to back from the reset state.
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].clr, vecs[i].we, vecs[i].be, vecs[i].data);
            check_all($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_pulse);
        end

        // Asynchronous reset mid-cycle, then reset overriding a write.
        apply(1'b0, 1'b1, 4'hF, 32'hDEADBEEF);
        check_all("pre_reset", 32'hDEADBEEF, 1'b1);
        WE = 1'b1; Data = 32'hCAFEF00D; ByteEn = 4'hF;
        #2;
        Rst_n = 1'b0;
        #1;
        check_all("async_reset", 32'h0, 1'b0);
        @(posedge Clk);
        #1;
        check_all("reset_hold", 32'h0, 1'b0);
        #3;
        Rst_n = 1'b1;
        apply(1'b0, 1'b1, 4'hF, 32'h0BADCAFE);
        check_all("first_edge", 32'h0BADCAFE, 1'b1);
        apply(1'b0, 1'b0, 4'hF, 32'h0);
        check_all("pulse_drop", 32'h0BADCAFE, 1'b0);

        // Randomized traffic against a word-level model.
        model_q = Dout === 32'h0BADCAFE ? 32'h0BADCAFE : 32'h0BADCAFE;
        for (int i = 0; i < 400; i++) begin
            rclr  = ($urandom_range(0, 9) == 0);
            rwe   = ($urandom_range(0, 2) != 0);
            rbe   = NBYTES'($urandom);
            rdata = $urandom;
            m = byte_mask(rbe);
            if (rclr) begin
                model_q     = '0;
                model_pulse = 1'b1;
            end else if (rwe) begin
                model_q     = (model_q & ~m) | (rdata & m);
                model_pulse = (rbe != 0);
            end else begin
                model_pulse = 1'b0;
            end
            apply(rclr, rwe, rbe, rdata);
            check_all($sformatf("rand%0d", i), model_q, model_pulse);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
